// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared state enum and width helpers for the button event controller
package button_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  // Event index width; a single-bit index is kept even for degenerate counts.
  function automatic int id_width(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

  function automatic int cnt_width(input int long_cycles);
    return $clog2(long_cycles + 1);
  endfunction

endpackage

// File: rtl/button_event_if.sv
// rtl/button_event_if.sv - valid/ready press event port between controller and consumer
interface button_event_if #(
  parameter int N_BTN = 4
);
  import button_event_pkg::*;

  localparam int ID_W = id_width(N_BTN);

  logic            ev_valid;
  logic            ev_ready;
  logic [ID_W-1:0] ev_id;
  logic            ev_long;

  modport master (
    output ev_valid,
    output ev_id,
    output ev_long,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_id,
    input  ev_long,
    output ev_ready
  );

endinterface

// File: rtl/btn_press_fsm.sv
// rtl/btn_press_fsm.sv - per-button press classifier emitting one short or long event per press
module btn_press_fsm
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES = 1000,
  parameter int CNT_W       = cnt_width(LONG_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic db,
  output logic gen,
  output logic gen_long
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CYCLES - 1);

  btn_state_e       state;
  btn_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the number of high samples seen so far in this press.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gen       = 1'b0;
    gen_long  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (db) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (db) begin
          if (cnt == CNT_LAST) begin
            state_nxt = ST_HELD;
            gen       = 1'b1;
            gen_long  = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
          gen       = 1'b1;
        end
      end
      ST_HELD: begin
        if (!db) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - per-button press FSMs, pending slots and round-robin event output
module button_event_ctrl
  import button_event_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int LONG_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] db_in,
  output logic             ev_drop,
  button_event_if.master   ev
);

  localparam int ID_W = id_width(N_BTN);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_BTN - 1);

  logic [N_BTN-1:0] gen;
  logic [N_BTN-1:0] gen_long;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] pend_long;
  logic [N_BTN-1:0] pend_nxt;
  logic [N_BTN-1:0] pend_long_nxt;
  logic [N_BTN-1:0] grant;
  logic [ID_W-1:0]  rr;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             slot_free;
  logic             drop_now;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_press_fsm #(
      .LONG_CYCLES(LONG_CYCLES)
    ) u_fsm (
      .clk     (clk),
      .rst     (rst),
      .db      (db_in[i]),
      .gen     (gen[i]),
      .gen_long(gen_long[i])
    );
  end

  assign slot_free = !ev.ev_valid || ev.ev_ready;

  // Two passes: indices at or above rr first, then wrap around from zero.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int j = 0; j < N_BTN; j++) begin
      if (!found && pend[j] && (ID_W'(j) >= rr)) begin
        found  = 1'b1;
        winner = ID_W'(j);
      end
    end
    for (int j = 0; j < N_BTN; j++) begin
      if (!found && pend[j]) begin
        found  = 1'b1;
        winner = ID_W'(j);
      end
    end
  end

  // A same-edge grant frees the slot, so a new event then replaces rather than drops.
  always_comb begin
    grant         = '0;
    pend_nxt      = pend;
    pend_long_nxt = pend_long;
    drop_now      = 1'b0;
    for (int j = 0; j < N_BTN; j++) begin
      grant[j] = slot_free && found && (winner == ID_W'(j));
      if (grant[j]) begin
        pend_nxt[j] = 1'b0;
      end
      if (gen[j]) begin
        if (pend[j] && !grant[j]) begin
          drop_now = 1'b1;
        end else begin
          pend_nxt[j]      = 1'b1;
          pend_long_nxt[j] = gen_long[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend        <= '0;
      pend_long   <= '0;
      rr          <= '0;
      ev_drop     <= 1'b0;
      ev.ev_valid <= 1'b0;
      ev.ev_id    <= '0;
      ev.ev_long  <= 1'b0;
    end else begin
      pend      <= pend_nxt;
      pend_long <= pend_long_nxt;
      if (drop_now) begin
        ev_drop <= 1'b1;
      end
      if (slot_free) begin
        if (found) begin
          ev.ev_valid <= 1'b1;
          ev.ev_id    <= winner;
          ev.ev_long  <= pend_long[winner];
          rr          <= (winner == ID_LAST) ? '0 : winner + 1'b1;
        end else begin
          ev.ev_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - scoreboard bench for button_event_ctrl with N_BTN=4, LONG_CYCLES=8
module tb_button_event_ctrl;

  localparam int N  = 4;
  localparam int LC = 8;

  typedef struct packed {
    logic [1:0] id;
    logic       lng;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] db_in = '0;
  logic         ev_drop;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  button_event_if #(.N_BTN(N)) evif ();

  button_event_ctrl #(
    .N_BTN      (N),
    .LONG_CYCLES(LC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .db_in  (db_in),
    .ev_drop(ev_drop),
    .ev     (evif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int id, input bit lng);
    ev_t e;
    e.id  = 2'(id);
    e.lng = lng;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted event must match the head of the expected queue.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst && evif.ev_valid && evif.ev_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: got id=%0d long=%0b expected none",
                   evif.ev_id, evif.ev_long);
        end else begin
          e = exp_q.pop_front();
          check("ev_id", 32'(evif.ev_id), 32'(e.id));
          check("ev_long", 32'(evif.ev_long), 32'(e.lng));
        end
      end
    end
  end

  initial begin
    evif.ev_ready = 1'b1;

    // Reset with random button levels
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      db_in = 4'($urandom);
      tick();
    end
    check("rst_valid", 32'(evif.ev_valid), 0);
    check("rst_id", 32'(evif.ev_id), 0);
    check("rst_long", 32'(evif.ev_long), 0);
    check("rst_drop", 32'(ev_drop), 0);
    db_in = '0;
    rst   = 1'b1;
    tick(5);
    check("idle_after_reset", 32'(evif.ev_valid), 0);

    // Short press, L=3 on button 2
    db_in[2] = 1'b1;
    tick(3);
    db_in[2] = 1'b0;
    push(2, 1'b0);
    tick();
    check("short_edge0_valid", 32'(evif.ev_valid), 0);
    tick();
    check("short_edge1_valid", 32'(evif.ev_valid), 1);
    tick();
    check("short_one_cycle", 32'(evif.ev_valid), 0);

    // Long press, 20 high samples on button 1
    push(1, 1'b1);
    db_in[1] = 1'b1;
    tick(8);
    check("long_edge0_valid", 32'(evif.ev_valid), 0);
    tick();
    check("long_edge1_valid", 32'(evif.ev_valid), 1);
    check("long_flag", 32'(evif.ev_long), 1);
    tick(11);
    db_in[1] = 1'b0;
    tick(4);
    check("no_event_on_release", 32'(evif.ev_valid), 0);

    // Boundary: L=7 short, L=8 long
    db_in[1] = 1'b1;
    tick(7);
    db_in[1] = 1'b0;
    push(1, 1'b0);
    tick(4);
    push(1, 1'b1);
    db_in[1] = 1'b1;
    tick(8);
    db_in[1] = 1'b0;
    tick(4);

    // Simultaneous releases on buttons 0 and 3 with rr=0
    rst = 1'b0;
    tick();
    rst   = 1'b1;
    db_in = 4'b1001;
    tick(2);
    db_in = '0;
    push(0, 1'b0);
    push(3, 1'b0);
    tick(2);
    check("sim_first_id", 32'(evif.ev_id), 0);
    tick();
    check("sim_second_valid", 32'(evif.ev_valid), 1);
    check("sim_second_id", 32'(evif.ev_id), 3);
    tick(3);
    // rr wrapped to 0: button 1 wins over button 3
    db_in = 4'b1010;
    tick(2);
    db_in = '0;
    push(1, 1'b0);
    push(3, 1'b0);
    tick(2);
    check("wrap_valid", 32'(evif.ev_valid), 1);
    check("wrap_first_id", 32'(evif.ev_id), 1);
    tick(4);

    // Backpressure: three short presses on button 2, third is dropped
    evif.ev_ready = 1'b0;
    push(2, 1'b0);
    push(2, 1'b0);
    for (int p = 0; p < 3; p++) begin
      db_in[2] = 1'b1;
      tick(2);
      db_in[2] = 1'b0;
      tick(2);
      if (p == 1) check("drop_before_third", 32'(ev_drop), 0);
    end
    check("drop_after_third", 32'(ev_drop), 1);
    check("stall_valid", 32'(evif.ev_valid), 1);
    check("stall_id", 32'(evif.ev_id), 2);
    evif.ev_ready = 1'b1;
    tick(5);
    check("drained_valid", 32'(evif.ev_valid), 0);
    check("drop_sticky", 32'(ev_drop), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("drop_cleared", 32'(ev_drop), 0);

    // Reset mid-press: 5 samples forgotten, then L=3 short
    db_in[1] = 1'b1;
    tick(5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick(3);
    db_in[1] = 1'b0;
    push(1, 1'b0);
    tick(6);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
